// File: rtl/pipe_stage_reg.sv
// Flushable pipeline stage register: valid/ready handshake, registered in_ready,
// and a two-entry (main + skid) buffer so downstream stalls never need a combinational ready path.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CTRL_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]        occ_q, occ_d;
  logic              in_ready_q, in_ready_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
  logic              acc, drn;

  assign acc = in_valid & in_ready_q;
  assign drn = out_valid & out_ready;

  always_comb begin
    // NOTE: every next-state signal gets a hold default first, so no path through the case infers a latch.
    occ_d    = occ_q;
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;

    if (flush) begin
      // Squashed slots lose their control bits; payload registers are left untouched.
      occ_d    = EMPTY;
      m_ctrl_d = '0;
      s_ctrl_d = '0;
    end else begin
      case (occ_q)
        EMPTY: begin
          if (acc) begin
            occ_d    = ONE;
            m_ctrl_d = in_ctrl;
            m_data_d = in_data;
          end
        end
        ONE: begin
          if (acc && drn) begin
            m_ctrl_d = in_ctrl;
            m_data_d = in_data;
          end else if (acc) begin
            occ_d    = FULL;
            s_ctrl_d = in_ctrl;
            s_data_d = in_data;
          end else if (drn) begin
            occ_d    = EMPTY;
            m_ctrl_d = '0;
          end
        end
        FULL: begin
          // in_ready is low here, so only a drain can happen: the skid entry moves up.
          if (drn) begin
            occ_d    = ONE;
            m_ctrl_d = s_ctrl_q;
            m_data_d = s_data_q;
            s_ctrl_d = '0;
          end
        end
        default: begin
          occ_d    = EMPTY;
          m_ctrl_d = '0;
          s_ctrl_d = '0;
        end
      endcase
    end

    in_ready_d = (occ_d < FULL);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      occ_q      <= EMPTY;
      in_ready_q <= 1'b1;
      m_ctrl_q   <= '0;
      m_data_q   <= '0;
      s_ctrl_q   <= '0;
      s_data_q   <= '0;
    end else begin
      occ_q      <= occ_d;
      in_ready_q <= in_ready_d;
      m_ctrl_q   <= m_ctrl_d;
      m_data_q   <= m_data_d;
      s_ctrl_q   <= s_ctrl_d;
      s_data_q   <= s_data_d;
    end
  end

  assign occupancy = occ_q;
  assign in_ready  = in_ready_q;
  assign out_valid = (occ_q != EMPTY);
  assign out_ctrl  = out_valid ? m_ctrl_q : '0;
  assign out_data  = m_data_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus random back-pressure,
// compared each cycle against a queue-based model of the stage contents.
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned CTRL_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } item_t;

  // Model: the held instructions in order, the upstream-visible ready, and the last shown payload.
  item_t             mq[$];
  logic              m_ready = 1'b1;
  logic [DATA_W-1:0] m_last  = '0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic rst_v, input logic fl_v, input logic iv_v,
                            input logic [CTRL_W-1:0] c_v, input logic [DATA_W-1:0] d_v,
                            input logic or_v);
    item_t it;
    logic  take;
    logic  give;
    if (!rst_v) begin
      mq.delete();
      m_last = '0;
    end else begin
      give = (mq.size() != 0) && or_v;
      take = iv_v && m_ready;
      if (fl_v) begin
        mq.delete();
      end else begin
        if (give) void'(mq.pop_front());
        if (take) begin
          it.ctrl = c_v;
          it.data = d_v;
          mq.push_back(it);
        end
      end
    end
    if (mq.size() != 0) m_last = mq[0].data;
    m_ready = (mq.size() < 2);
  endtask

  task automatic compare_model();
    logic [CTRL_W-1:0] exp_ctrl;
    exp_ctrl = (mq.size() != 0) ? mq[0].ctrl : '0;
    check("out_valid", 128'(out_valid), 128'(mq.size() != 0));
    check("out_ctrl",  128'(out_ctrl),  128'(exp_ctrl));
    check("out_data",  128'(out_data),  128'(m_last));
    check("in_ready",  128'(in_ready),  128'(m_ready));
    check("occupancy", 128'(occupancy), 128'(mq.size()));
  endtask

  // One clock: drive inputs, advance the model at the edge, compare on the falling edge.
  task automatic cyc(input logic rst_v, input logic fl_v, input logic iv_v,
                     input logic [CTRL_W-1:0] c_v, input logic [DATA_W-1:0] d_v,
                     input logic or_v);
    reset     = rst_v;
    flush     = fl_v;
    in_valid  = iv_v;
    in_ctrl   = c_v;
    in_data   = d_v;
    out_ready = or_v;
    @(posedge clk);
    model_step(rst_v, fl_v, iv_v, c_v, d_v, or_v);
    @(negedge clk);
    compare_model();
  endtask

  initial begin
    // Reset state
    cyc(1'b0, 1'b1, 1'b1, 8'h77, 128'd99, 1'b1);
    check("rst_occ",   128'(occupancy), 128'd0);
    check("rst_ready", 128'(in_ready),  128'd1);
    check("rst_data",  128'(out_data),  128'd0);
    check("rst_ctrl",  128'(out_ctrl),  128'd0);

    // Stream 1..8 with out_ready held high
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 8'hA5, 128'(i), 1'b1);
      check("stream_data",  128'(out_data),  128'(i));
      check("stream_valid", 128'(out_valid), 128'd1);
      check("stream_ctrl",  128'(out_ctrl),  128'hA5);
      check("stream_ready", 128'(in_ready),  128'd1);
    end

    // Stall absorb: 10 in M, stall 4 cycles while offering 11 then 12
    cyc(1'b1, 1'b0, 1'b1, 8'h3C, 128'd10, 1'b1);
    check("stall_pre", 128'(out_data), 128'd10);
    cyc(1'b1, 1'b0, 1'b1, 8'h3C, 128'd11, 1'b0);
    check("stall1_data",  128'(out_data),  128'd10);
    check("stall1_occ",   128'(occupancy), 128'd2);
    check("stall1_ready", 128'(in_ready),  128'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 1'b1, 8'h3C, 128'd12, 1'b0);
      check("stall_hold", 128'(out_data),  128'd10);
      check("stall_occ",  128'(occupancy), 128'd2);
    end
    cyc(1'b1, 1'b0, 1'b1, 8'h3C, 128'd12, 1'b1);
    check("release_11",    128'(out_data), 128'd11);
    check("release_ready", 128'(in_ready), 128'd1);
    cyc(1'b1, 1'b0, 1'b1, 8'h3C, 128'd12, 1'b1);
    check("release_12", 128'(out_data), 128'd12);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 128'd0, 1'b1);
    check("release_empty", 128'(out_valid), 128'd0);

    // Flush while FULL, with an input offered
    cyc(1'b1, 1'b0, 1'b1, 8'h5A, 128'd20, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 8'h5A, 128'd21, 1'b0);
    check("full_occ", 128'(occupancy), 128'd2);
    cyc(1'b1, 1'b1, 1'b1, 8'h5A, 128'd22, 1'b0);
    check("flush_occ",   128'(occupancy), 128'd0);
    check("flush_valid", 128'(out_valid), 128'd0);
    check("flush_ctrl",  128'(out_ctrl),  128'd0);
    check("flush_ready", 128'(in_ready),  128'd1);
    check("flush_data",  128'(out_data),  128'd20);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 128'd0, 1'b1);
    check("flush_no_22", 128'(out_valid), 128'd0);

    // Flush in ONE with a simultaneous accept and drain: the new input is dropped
    cyc(1'b1, 1'b0, 1'b1, 8'h11, 128'd50, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 8'h11, 128'd51, 1'b1);
    check("flush1_valid", 128'(out_valid), 128'd0);
    check("flush1_data",  128'(out_data),  128'd50);

    // Bubble gating: one transfer with ctrl FF, then idle
    cyc(1'b1, 1'b0, 1'b1, 8'hFF, 128'd30, 1'b1);
    check("bubble_ctrl0", 128'(out_ctrl), 128'hFF);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'hFF, 128'd31, 1'b1);
      check("bubble_ctrl",  128'(out_ctrl),  128'd0);
      check("bubble_valid", 128'(out_valid), 128'd0);
      check("bubble_data",  128'(out_data),  128'd30);
    end

    // Mid-stream reset while FULL, with input offered and flush asserted
    cyc(1'b1, 1'b0, 1'b1, 8'h44, 128'd40, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 8'h44, 128'd41, 1'b0);
    check("pre_rst_occ", 128'(occupancy), 128'd2);
    cyc(1'b0, 1'b1, 1'b1, 8'h44, 128'd42, 1'b1);
    check("mid_rst_data",  128'(out_data),  128'd0);
    check("mid_rst_ready", 128'(in_ready),  128'd1);
    check("mid_rst_occ",   128'(occupancy), 128'd0);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 128'd0, 1'b1);
    check("mid_rst_no_42", 128'(out_valid), 128'd0);

    // Random back-pressure against the model
    for (int n = 0; n < 10000; n++) begin
      cyc(1'b1,
          ($urandom_range(0, 63) == 0),
          1'($urandom_range(0, 1)),
          8'($urandom),
          {$urandom, $urandom, $urandom, $urandom},
          ($urandom_range(0, 3) != 0) ? 1'($urandom_range(0, 1)) : 1'b1);
      check("occ_le_2", 128'(occupancy <= 2'd2), 128'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, flushable pipeline stage register with a valid/ready handshake and a two-entry skid buffer. It replaces fixed per-stage registers such as ID/EX and EX/MEM. Downstream stalls back-pressure upstream without a combinational ready path. A bubble always carries all-zero control bits, so a squashed slot can never write memory or the register file.

## Interface
Parameters:
- DATA_W, 128, width of the payload bus (operands, PC, register indices); never cleared by a bubble.
- CTRL_W, 8, width of the control bus (MemWr, MemRd, RegWr, ALUFun, ...); forced to zero whenever the slot is not valid.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  upstream slot holds a real instruction.
- in_ready  output  1  stage can accept this cycle; registered.
- in_ctrl  input  CTRL_W  upstream control bits.
- in_data  input  DATA_W  upstream payload.
- flush  input  1  squash everything held and anything accepted this cycle.
- out_valid  output  1  out_ctrl/out_data hold a real instruction.
- out_ready  input  1  downstream consumes this cycle; low = hold (stall).
- out_ctrl  output  CTRL_W  control bits; 0 whenever out_valid = 0.
- out_data  output  DATA_W  payload; holds its last value when not valid.
- occupancy  output  2  entries held: 0, 1 or 2.

## Operation
- Storage: main entry (M) drives the outputs; skid entry (S) is filled only when M is held.
- Accept: acc = in_valid & in_ready.
- Drain: drn = out_valid & out_ready.
- States, encoded as occupancy:
  - EMPTY (0): acc -> ONE, load M.
  - ONE (1):
    - acc & drn -> ONE, reload M.
    - acc & !drn -> FULL, load S.
    - !acc & drn -> EMPTY.
    - else hold.
  - FULL (2): in_ready = 0, so acc is impossible. drn -> ONE, S moves to M. Else hold.
- in_ready is registered: next in_ready = (next occupancy < 2).
- out_valid = (occupancy != 0), decoded from state registers.
- out_ctrl = M.ctrl when valid, else 0. M.ctrl and S.ctrl registers are cleared whenever their entry is invalidated.
- flush, highest priority:
  - Next state EMPTY; both entries invalid; both ctrl registers cleared; in_ready = 1 next cycle.
  - An acc or drn in the same cycle is ignored: the upstream data is dropped and the downstream drain is still counted as consumed.
  - Data registers are not cleared.
- Order is preserved: S is always younger than M. S never bypasses M.

## Timing
- Reset (reset = 0 at a clk edge) sets:
  - occupancy = 0, out_valid = 0, out_ctrl = 0, out_data = 0, in_ready = 1.
  - The S registers are cleared.
  - in_valid, flush and out_ready are ignored in that cycle.
- Reset mid-operation discards both entries with no partial drain; it behaves exactly as at power-up.
- Latency: data accepted at edge N appears on out_data/out_valid after edge N, i.e. 1 cycle.
- Throughput: 1 per cycle while out_ready = 1 continuously.
- Stall: out_ready low for k cycles with continuous input holds M constant.
  - The first input is absorbed into S and in_ready falls one cycle later.
  - At most one extra transfer is accepted after out_ready falls.
- Release: after out_ready rises from FULL, in_ready rises one edge later. No cycle drops data, and none duplicates it.
- Simultaneous flush + reset: reset wins; the result is identical to a plain reset.
- There are no combinational paths from out_ready to in_ready, or from in_valid to out_valid.

## Test plan
- Reset then stream: hold out_ready = 1 and feed data 1..8 on consecutive cycles with ctrl = 8'hA5.
  - out_data shows 1..8 exactly one cycle behind the input.
  - out_valid stays 1 throughout and in_ready never drops.
- Stall absorb: drop out_ready for 4 cycles while feeding 10, 11, 12, ...
  - out_data holds 10 for the whole stall.
  - Entry 11 goes into S; in_ready = 0 from the second stalled cycle; occupancy = 2.
  - On release, outputs are 10, 11, 12 with no loss or duplicates.
- Flush in FULL: with occupancy = 2, assert flush together with in_valid.
  - Next cycle: occupancy = 0, out_valid = 0, out_ctrl = 0, in_ready = 1.
  - The flushed-cycle input never appears on the output.
- Bubble control gating: idle the input for 3 cycles after one transfer with ctrl = 8'hFF.
  - out_ctrl = 0 and out_valid = 0 from the second cycle onward.
  - out_data keeps the last payload.
- Mid-stream reset: drive reset = 0 for one cycle while in FULL state.
  - Next cycle all outputs are at their reset values: out_data = 0, in_ready = 1, occupancy = 0.
  - An in_valid presented during the reset cycle is not accepted.
- Random back-pressure: drive in_valid and out_ready randomly for 10^4 cycles with a scoreboard.
  - Output order and content match accepted input exactly.
  - occupancy never exceeds 2.
